// File: rtl/gerador_janela.sv
// rtl/gerador_janela.sv - 3x3 sliding-window generator for a raster pixel stream
//
// Purpose: turns a raster-order 8-bit pixel stream into 3x3 windows for a
// median filter. Two line buffers hold the previous two image lines. Three
// 2-deep shift registers hold columns c-2 and c-1 of the three window rows.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pix_in       incoming pixel, raster order
//   pix_valid    pix_in accepted on this edge (no backpressure)
//   sof          start of frame, qualified by pix_valid; marks pixel (0,0)
//   E0..E8       window, row-major (E0 top-left, E4 centre, E8 bottom-right)
//   janela_valid one-cycle pulse when E0..E8 hold a complete new window
module gerador_janela #(
  parameter int LARGURA = 64,
  parameter int ALTURA  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] E0,
  output logic [7:0] E1,
  output logic [7:0] E2,
  output logic [7:0] E3,
  output logic [7:0] E4,
  output logic [7:0] E5,
  output logic [7:0] E6,
  output logic [7:0] E7,
  output logic [7:0] E8,
  output logic       janela_valid
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int RW = (ALTURA  > 1) ? $clog2(ALTURA)  : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(LARGURA - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ALTURA - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Position of the pixel being accepted: sof forces (0,0) regardless of
  // where the counters currently are.
  logic [CW-1:0] pos_c;
  logic [RW-1:0] pos_r;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  // lb_prev holds line r-1, lb_prev2 holds line r-2, both indexed by column.
  logic [7:0] lb_prev  [LARGURA];
  logic [7:0] lb_prev2 [LARGURA];
  logic [7:0] rd_prev;
  logic [7:0] rd_prev2;

  // Column c-2 (x0) and c-1 (x1) for the top, middle and bottom rows.
  logic [7:0] t0, t1, m0, m1, b0, b1;

  always_comb begin
    pos_c = sof ? '0 : col;
    pos_r = sof ? '0 : row;
    if (pos_c == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (pos_r == ROW_LAST) ? '0 : pos_r + RW'(1);
    end else begin
      col_nxt = pos_c + CW'(1);
      row_nxt = pos_r;
    end
  end

  assign rd_prev  = lb_prev[pos_c];
  assign rd_prev2 = lb_prev2[pos_c];

  // Line buffers carry no reset: their contents are only ever read into a
  // signalled window after two full lines of the current frame overwrote them.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_prev2[pos_c] <= rd_prev;
      lb_prev[pos_c]  <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      t0           <= '0;
      t1           <= '0;
      m0           <= '0;
      m1           <= '0;
      b0           <= '0;
      b1           <= '0;
      E0           <= '0;
      E1           <= '0;
      E2           <= '0;
      E3           <= '0;
      E4           <= '0;
      E5           <= '0;
      E6           <= '0;
      E7           <= '0;
      E8           <= '0;
      janela_valid <= 1'b0;
    end else if (pix_valid) begin
      col <= col_nxt;
      row <= row_nxt;
      E0  <= t0;
      E1  <= t1;
      E2  <= rd_prev2;
      E3  <= m0;
      E4  <= m1;
      E5  <= rd_prev;
      E6  <= b0;
      E7  <= b1;
      E8  <= pix_in;
      t0  <= t1;
      t1  <= rd_prev2;
      m0  <= m1;
      m1  <= rd_prev;
      b0  <= b1;
      b1  <= pix_in;
      // Shift registers may still hold the previous line for c < 2, so those
      // windows are never signalled; same for rows 0 and 1 of a frame.
      janela_valid <= (pos_r >= ROW_TWO) && (pos_c >= COL_TWO);
    end else begin
      janela_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gerador_janela.sv
// tb/tb_gerador_janela.sv - self-checking bench for gerador_janela (4x4 image)
module tb_gerador_janela;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] E0, E1, E2, E3, E4, E5, E6, E7, E8;
  logic       janela_valid;

  gerador_janela #(.LARGURA(W), .ALTURA(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .E0(E0), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .E5(E5), .E6(E6), .E7(E7),
    .E8(E8), .janela_valid(janela_valid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: linear pixel index within the frame plus a frame image.
  int         k = 0;
  logic [7:0] img [H][W];
  logic [71:0] prev_obs = '0;

  logic [71:0] got_win [$];
  int          got_trig [$];

  function automatic logic [71:0] obs_win();
    return {E0, E1, E2, E3, E4, E5, E6, E7, E8};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input (starting at a negedge), predict, then check at
  // the following negedge.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    logic        ev;
    logic [71:0] ew;
    int r, c;
    ev = 1'b0;
    ew = '0;
    pix_valid = v;
    sof = s;
    pix_in = p;
    if (v) begin
      if (s) k = 0;
      r = k / W;
      c = k % W;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        ew = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
              img[r-1][c-2], img[r-1][c-1], img[r-1][c],
              img[r][c-2],   img[r][c-1],   img[r][c]};
      end
      k = (k + 1) % (W * H);
    end
    @(negedge clk);
    chk("janela_valid", {71'd0, janela_valid}, {71'd0, ev});
    if (ev) chk("window", obs_win(), ew);
    if (!v) chk("hold_idle", obs_win(), prev_obs);
    if (janela_valid) begin
      got_win.push_back(obs_win());
      got_trig.push_back(int'(p));
    end
    prev_obs = obs_win();
  endtask

  task automatic frame(input int base, input logic with_sof, input int gap);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, with_sof && (i == 0), 8'(base + i));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic check_ref_windows(input string tag);
    logic [71:0] exp_w [4];
    int          exp_t [4];
    exp_w[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    exp_w[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    exp_w[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    exp_w[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    exp_t[0] = 10; exp_t[1] = 11; exp_t[2] = 14; exp_t[3] = 15;
    chk({tag, "_count"}, 72'(got_win.size()), 72'd4);
    for (int i = 0; i < 4 && i < got_win.size(); i++) begin
      chk({tag, "_win"}, got_win[i], exp_w[i]);
      chk({tag, "_trig"}, 72'(got_trig[i]), 72'(exp_t[i]));
    end
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    sof = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {obs_win(), 7'd0, janela_valid}, 80'd0);
    rst = 1'b0;
    k = 0;
    prev_obs = obs_win();
  endtask

  initial begin
    // Reset state
    #1;
    chk("reset_initial", {obs_win(), 7'd0, janela_valid}, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_obs = obs_win();

    // Continuous frame with sof
    got_win.delete(); got_trig.delete();
    frame(0, 1'b1, 0);
    check_ref_windows("cont");

    // Same frame with 3 idle cycles after every pixel
    got_win.delete(); got_trig.delete();
    frame(0, 1'b1, 3);
    check_ref_windows("gaps");

    // Back-to-back frames, second without sof
    got_win.delete(); got_trig.delete();
    frame(0, 1'b1, 0);
    frame(100, 1'b0, 0);
    chk("b2b_count", 72'(got_win.size()), 72'd8);
    if (got_win.size() >= 5)
      chk("b2b_first2", got_win[4],
          {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110});

    // Reset after 7 pixels, then a new frame with no sof
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 8'(200 + i));
    do_reset();
    got_win.delete(); got_trig.delete();
    frame(0, 1'b0, 0);
    check_ref_windows("rst_mid");

    // sof reasserted on the 6th pixel
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 8'(30 + i));
    got_win.delete(); got_trig.delete();
    frame(50, 1'b1, 0);
    chk("sof_mid_count", 72'(got_win.size()), 72'd4);
    if (got_win.size() >= 1) begin
      chk("sof_mid_first", got_win[0],
          {8'd50, 8'd51, 8'd52, 8'd54, 8'd55, 8'd56, 8'd58, 8'd59, 8'd60});
      chk("sof_mid_trig", 72'(got_trig[0]), 72'd60);
    end

    // Randomized stream against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0, 8'($urandom));

    // Asynchronous reset while janela_valid is high
    for (int i = 0; i <= 10; i++) step(1'b1, i == 0, 8'(i));
    chk("async_pre_valid", {71'd0, janela_valid}, 72'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {obs_win(), 7'd0, janela_valid}, 80'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    prev_obs = obs_win();
    got_win.delete(); got_trig.delete();
    frame(0, 1'b0, 1);
    check_ref_windows("post_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gerador_janela.md
GERADOR_JANELA -- requirements
Module: gerador_janela

Interface
REQ-001 The block SHALL have parameter LARGURA, default 64, meaning image width in pixels (>= 3).
REQ-002 The block SHALL have parameter ALTURA, default 64, meaning image height in lines (>= 3).
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port pix_in  input  8  incoming pixel, raster order (left to right, top to bottom).
REQ-006 The block SHALL have port pix_valid  input  1  pix_in is accepted on this clock edge; no backpressure.
REQ-007 The block SHALL have port sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0).
REQ-008 The block SHALL have ports E0..E8  output  8 each  3x3 window, row-major: E0 is top-left, E4 is centre, E8 is bottom-right; they connect directly to the median filter inputs.
REQ-009 The block SHALL have port janela_valid  output  1  E0..E8 hold a complete new window this cycle.

Function
REQ-010 The block SHALL keep column counter col (0..LARGURA-1) and row counter row (0..ALTURA-1), both advanced only on accepted pixels.
REQ-011 On an accepted pixel, col SHALL wrap from LARGURA-1 to 0 and increment row; row SHALL wrap from ALTURA-1 to 0.
REQ-012 An accepted pixel with sof=1 SHALL be treated as (0,0): the next pixel is (0,1), whatever the prior counter state.
REQ-013 The block SHALL hold two line buffers of LARGURA x 8 bits, indexed by col, storing the previous two image lines.
REQ-014 On an accepted pixel at (r,c), the block SHALL produce a window with E0..E2 = line r-2, cols c-2..c; E3..E5 = line r-1, cols c-2..c; E6..E8 = line r, cols c-2..c.
REQ-015 janela_valid SHALL be asserted for exactly one cycle, on the cycle after the clock edge that accepts a pixel with r >= 2 and c >= 2; the latency is 1 clock.
REQ-016 Windows with r < 2 or c < 2 SHALL NOT be signalled: only (LARGURA-2)*(ALTURA-2) windows per frame, with centre pixel (r-1,c-1).
REQ-017 A window SHALL never mix pixels from different image lines across a col wrap, nor pixels from different frames.
REQ-018 When pix_valid=0, counters, buffers and E0..E8 SHALL hold their values, and janela_valid SHALL be 0 on the next cycle.
REQ-019 Arbitrary idle gaps between accepted pixels SHALL NOT change any window content.
REQ-020 A frame that ends with pixel (ALTURA-1, LARGURA-1) SHALL be followed by (0,0) with no sof required; back-to-back frames SHALL need no idle cycles.
REQ-021 A sof arriving mid-frame SHALL abandon the current frame; no window from the abandoned frame SHALL be signalled after the sof pixel is accepted.

Reset
REQ-022 While rst=1, col, row, E0..E8 and janela_valid SHALL be 0 asynchronously; line-buffer contents are don't-care.
REQ-023 The first accepted pixel after rst deasserts SHALL be treated as (0,0).
REQ-024 Reset mid-frame SHALL discard the partial frame; no window SHALL be signalled until two full lines plus three pixels of new data are accepted.

Verification (LARGURA=4, ALTURA=4)
REQ-025 Pixels 0..15 raster, pix_valid held high, sof on the first pixel -> exactly 4 janela_valid pulses, each 1 cycle after the pixels with values 10, 11, 14 and 15; E0..E8 = {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
REQ-026 Same stream with pix_valid deasserted for 3 cycles after every pixel -> identical 4 windows in the same order, each pulse 1 cycle wide.
REQ-027 Two frames back-to-back (values 0..15, then 100..115, no sof on the second) -> the second frame's first window is {100,101,102,104,105,106,108,109,110}, with no window mixing the two frames.
REQ-028 rst pulsed after 7 pixels of a frame, then a new frame 0..15 -> no janela_valid before the pixel with value 10 of the new frame; windows as in REQ-025.
REQ-029 sof reasserted on the 6th pixel of a frame, followed by that frame's data 50..65 -> the first window is {50,51,52,54,55,56,58,59,60}, and no earlier pulse occurs after the sof.
REQ-030 rst asserted asynchronously between clock edges while janela_valid=1 -> janela_valid and E0..E8 go to 0 immediately.
